// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with stall hold buffer and redirect.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_plus_two,
    output logic [15:0] instruction,
    output logic        fetch_valid
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_buf, w_buf_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic [15:0] r_pc2, w_pc2_nxt;
    logic        r_valid, w_valid_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_buf   <= 16'h0000;
            r_instr <= NOP_INSTR;
            r_pc2   <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_buf   <= w_buf_nxt;
            r_instr <= w_instr_nxt;
            r_pc2   <= w_pc2_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_instr_nxt = r_instr;
        w_pc2_nxt   = r_pc2;
        w_valid_nxt = r_valid;

        if (redirect) begin
            // Whatever memory returns this cycle belongs to the old path.
            w_state_nxt = S_FETCH;
            w_pc_nxt    = redirect_pc & 16'hFFFE;
            w_buf_nxt   = 16'h0000;
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (stall) begin
                        if (imem_ready) begin
                            w_buf_nxt   = imem_rdata;
                            w_pc_nxt    = r_pc + 16'd2;
                            w_state_nxt = S_HOLD;
                        end
                    end else if (imem_ready) begin
                        w_instr_nxt = imem_rdata;
                        w_pc2_nxt   = r_pc + 16'd2;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_pc + 16'd2;
                    end else begin
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    // pc was already advanced when the word was buffered.
                    if (!stall) begin
                        w_instr_nxt = r_buf;
                        w_pc2_nxt   = r_pc;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign PC_plus_two = r_pc2;
    assign fetch_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ready;
    logic [15:0] redirect_pc;

    logic        req0, req1, val0, val1;
    logic [15:0] addr0, addr1, rdata0, rdata1, pc2_0, pc2_1, ins0, ins1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Memory model: each word encodes its own address.
    assign rdata0 = 16'hA000 + addr0;
    assign rdata1 = 16'hA000 + addr1;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req0), .imem_addr(addr0),
        .imem_ready(imem_ready), .imem_rdata(rdata0), .PC_plus_two(pc2_0),
        .instruction(ins0), .fetch_valid(val0)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .NOP_INSTR(NOP)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req1), .imem_addr(addr1),
        .imem_ready(imem_ready), .imem_rdata(rdata1), .PC_plus_two(pc2_1),
        .instruction(ins1), .fetch_valid(val1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic out0(input string tag, input logic [15:0] ins, input logic [15:0] pc2,
                        input logic val);
        check({tag, ".instr"}, ins0, ins);
        check({tag, ".pc2"}, pc2_0, pc2);
        check({tag, ".valid"}, {15'd0, val0}, {15'd0, val});
    endtask

    task automatic mem0(input string tag, input logic req, input logic [15:0] addr);
        check({tag, ".req"}, {15'd0, req0}, {15'd0, req});
        if (req) check({tag, ".addr"}, addr0, addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; redirect_pc = 16'h0000;
        step(); step();
        out0("reset", NOP, 16'h0000, 1'b0);
        mem0("reset", 1'b1, 16'h0000);

        // Streaming
        rst = 1'b0; imem_ready = 1'b1;
        mem0("first_fetch", 1'b1, 16'h0000);
        step(); out0("stream0", 16'hA000, 16'h0002, 1'b1);
        step(); out0("stream1", 16'hA002, 16'h0004, 1'b1);
        step(); out0("stream2", 16'hA004, 16'h0006, 1'b1);
        step(); out0("stream3", 16'hA006, 16'h0008, 1'b1);

        // Redirect to 0x000E (odd bit dropped); fetched data that cycle is discarded
        redirect = 1'b1; redirect_pc = 16'h000F;
        step(); out0("redir0", NOP, 16'h0008, 1'b0);
        mem0("redir0", 1'b1, 16'h000E);
        redirect = 1'b0;
        step(); out0("post_redir0", 16'hA00E, 16'h0010, 1'b1);

        // Stall three cycles at pc 0x0010 with memory ready
        stall = 1'b1;
        step(); out0("stall1", 16'hA00E, 16'h0010, 1'b1); mem0("stall1", 1'b0, 16'h0000);
        step(); out0("stall2", 16'hA00E, 16'h0010, 1'b1); mem0("stall2", 1'b0, 16'h0000);
        step(); out0("stall3", 16'hA00E, 16'h0010, 1'b1); mem0("stall3", 1'b0, 16'h0000);
        stall = 1'b0;
        step(); out0("unstall", 16'hA010, 16'h0012, 1'b1);
        mem0("unstall", 1'b1, 16'h0012);
        step(); out0("after_hold", 16'hA012, 16'h0014, 1'b1);

        // Slow memory at 0x0020
        redirect = 1'b1; redirect_pc = 16'h0020;
        step(); out0("redir1", NOP, 16'h0014, 1'b0);
        redirect = 1'b0; imem_ready = 1'b0;
        step(); out0("slow1", NOP, 16'h0014, 1'b0); mem0("slow1", 1'b1, 16'h0020);
        step(); out0("slow2", NOP, 16'h0014, 1'b0); mem0("slow2", 1'b1, 16'h0020);
        imem_ready = 1'b1;
        step(); out0("slow_done", 16'hA020, 16'h0022, 1'b1);

        // Redirect while holding a buffered word
        stall = 1'b1;
        step(); out0("hold_pre", 16'hA020, 16'h0022, 1'b1); mem0("hold_pre", 1'b0, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h0101;
        step(); out0("hold_redir", NOP, 16'h0022, 1'b0); mem0("hold_redir", 1'b1, 16'h0100);
        redirect = 1'b0; stall = 1'b0;
        step(); out0("post_redir1", 16'hA100, 16'h0102, 1'b1);

        // Reset asserted mid-HOLD
        stall = 1'b1;
        step(); mem0("hold_rst_pre", 1'b0, 16'h0000);
        rst = 1'b1;
        step(); out0("rst_hold", NOP, 16'h0000, 1'b0); mem0("rst_hold", 1'b1, 16'h0000);
        check("rst_hold.addr1", addr1, 16'hFFFE);
        check("rst_hold.pc2_1", pc2_1, 16'h0000);
        rst = 1'b0; stall = 1'b0;

        // Wrap from 0xFFFE on the second instance
        step();
        check("wrap.instr1", ins1, 16'h9FFE);
        check("wrap.pc2_1", pc2_1, 16'h0000);
        check("wrap.valid1", {15'd0, val1}, 16'h0001);
        check("wrap.addr1", addr1, 16'h0000);
        out0("rst_stream", 16'hA000, 16'h0002, 1'b1);
        step();
        check("wrap2.instr1", ins1, 16'hA000);
        check("wrap2.pc2_1", pc2_1, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'h0000, meaning the instruction word driven during a bubble.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: downstream (IF/ID) cannot accept; hold the presented outputs.
REQ-006 The block SHALL have port redirect, input, 1 bit: branch/jump taken; refetch from redirect_pc.
REQ-007 The block SHALL have port redirect_pc, input, 16 bits: redirect target; bit 0 ignored and treated as 0.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-009 The block SHALL have port imem_addr, output, 16 bits: fetch address, equal to pc.
REQ-010 The block SHALL have port imem_ready, input, 1 bit: imem_rdata valid this cycle for the current imem_addr.
REQ-011 The block SHALL have port imem_rdata, input, 16 bits: fetched instruction word.
REQ-012 The block SHALL have port PC_plus_two, output, 16 bits: address of the presented instruction plus 2, registered.
REQ-013 The block SHALL have port instruction, output, 16 bits: presented instruction, registered.
REQ-014 The block SHALL have port fetch_valid, output, 1 bit: 1 = instruction is real; 0 = bubble.

Function
REQ-015 The block SHALL keep a 16-bit pc register and a 2-state FSM: FETCH, HOLD.
REQ-016 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc; in HOLD, it SHALL drive imem_req=0.
REQ-017 FETCH, imem_ready=1, stall=0, redirect=0: next cycle instruction=imem_rdata, PC_plus_two=pc+2, fetch_valid=1, pc=pc+2; stay in FETCH.
REQ-018 FETCH, imem_ready=0, stall=0, redirect=0: next cycle instruction=NOP_INSTR, fetch_valid=0, PC_plus_two unchanged, pc unchanged (bubble).
REQ-019 FETCH, stall=1, redirect=0: outputs SHALL hold; if imem_ready=1, imem_rdata SHALL be captured into a 16-bit hold buffer, pc=pc+2, go to HOLD; if imem_ready=0, no change.
REQ-020 HOLD, stall=1, redirect=0: outputs, buffer, and pc SHALL hold.
REQ-021 HOLD, stall=0, redirect=0: next cycle instruction=buffer, PC_plus_two=pc (already incremented), fetch_valid=1; go to FETCH.
REQ-022 redirect=1 in any state SHALL override stall and imem_ready: pc={redirect_pc[15:1],1'b0}, buffer discarded, instruction=NOP_INSTR, fetch_valid=0, PC_plus_two unchanged; go to FETCH.
REQ-023 Any imem_rdata returned in the cycle redirect=1 SHALL be dropped and never presented.
REQ-024 All pc and PC_plus_two arithmetic SHALL be modulo 2^16: pc=16'hFFFE advances to 16'h0000, with PC_plus_two=16'h0000.
REQ-025 The memory SHALL tolerate imem_addr changing while imem_ready=0; no request is left outstanding across a redirect.
REQ-026 No instruction SHALL be presented twice or skipped except as discarded by a redirect.

Reset
REQ-027 rst=1 at posedge clk SHALL set pc=RESET_PC, state=FETCH, instruction=NOP_INSTR, PC_plus_two=16'h0000, fetch_valid=0, and clear the hold buffer.
REQ-028 rst SHALL take priority over redirect, stall, and imem_ready, including mid-HOLD.
REQ-029 In the first cycle after rst deasserts, imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-030 Streaming case: reset, imem_ready=1, rdata=16'hA000+addr, 4 cycles -> outputs (instr, PC_plus_two) are (A000,0002), (A002,0004), (A004,0006), (A006,0008), with fetch_valid=1 throughout.
REQ-031 Stall with return: stall=1 for 3 cycles while ready=1 at pc=0x0010 -> outputs frozen, state HOLD, imem_req=0; after stall drops, the next output is (rdata@0x0010, 0x0012) with no duplicate or gap.
REQ-032 Slow memory: ready=0 for 2 cycles at pc=0x0020 -> two bubbles (fetch_valid=0, instr=NOP_INSTR, imem_addr stays 0x0020), then (rdata@0x0020, 0x0022).
REQ-033 Redirect: redirect=1 with redirect_pc=0x0101, concurrent with stall=1 in HOLD -> next cycle bubble and imem_addr=0x0100; the buffered word is never presented; the next valid output is (rdata@0x0100, 0x0102).
REQ-034 Wrap and reset: RESET_PC=16'hFFFE -> first output (rdata@FFFE, 0x0000), then imem_addr=0x0000; rst asserted mid-HOLD -> next cycle all reset values per REQ-027.
